// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, reset PC,
// fetch FSM encoding and small helpers.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int IMEM_ADDR_W = 8;
    localparam logic [IMEM_ADDR_W-1:0] RESET_PC = 8'h00;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } fetch_state_t;

    function automatic logic [15:0] sat_inc16(
        input logic [15:0] v
    );
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction memory request/response
// plus the valid/ready handshake towards decode.
interface instr_fetch_unit_if
    import riscv_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);

    logic [ADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]   imem_instr;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with flush; the head reads
// as zero whenever the buffer is empty.
module fetch_fifo #(
    parameter int DW = 40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is gated by count.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, BOOT/RUN/HALT control, redirect
// flush and a 2-deep buffer presented to decode.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       fetch_count,
    instr_fetch_unit_if.master bus
);

    localparam int DW = ADDR_W + XLEN;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       fcnt_q, fcnt_d;

    logic          push;
    logic          pop;
    logic [1:0]    fifo_cnt;
    logic [DW-1:0] fifo_dout;

    assign pop = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fcnt_d  = fcnt_q;
        push    = 1'b0;
        unique case (state_q)
            ST_BOOT: state_d = fetch_en ? ST_RUN : ST_HALT;
            ST_RUN: begin
                if (!fetch_en) state_d = ST_HALT;
                else if (fifo_cnt < 2'd2 || pop) push = 1'b1;
            end
            ST_HALT: if (fetch_en) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
        // Redirect wins; it leaves RUN/HALT where they are.
        if (redirect_valid) begin
            push = 1'b0;
            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            if (state_q != ST_BOOT) state_d = state_q;
        end
        if (push) begin
            pc_d   = pc_q + ADDR_W'(4);
            fcnt_d = sat_inc16(fcnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
        end
    end

    fetch_fifo #(
        .DW(DW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(redirect_valid),
        .din_i  ({pc_q, bus.imem_instr}),
        .dout_o (fifo_dout),
        .count_o(fifo_cnt)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.out_pc    = fifo_dout[DW-1:XLEN];
    assign bus.out_instr = fifo_dout[XLEN-1:0];
    assign fetch_count   = fcnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table-driven backpressure run
// plus directed sequences, with a decode-side scoreboard.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [15:0] fetch_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic        fen;
        logic        rdy;
        logic        v;
        logic [7:0]  pc;
        logic [7:0]  addr;
        logic [15:0] fc;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];

    instr_fetch_unit_if #(.ADDR_W(8)) bus();

    instr_fetch_unit #(
        .ADDR_W  (8),
        .RESET_PC(8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_count   (fetch_count),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(
        input logic [7:0] a
    );
        case (a)
            8'h00:   return 32'h0000_7033;
            8'h04:   return 32'h0030_0093;
            8'h08:   return 32'h0020_0113;
            8'h24:   return 32'h0051_0293;
            default: return {16'hC0DE, 8'h00, a};
        endcase
    endfunction

    assign bus.imem_instr = imem_word(bus.imem_addr);

    task automatic chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [7:0] pc);
        exp_t e;
        e.pc = pc;
        e.instr = imem_word(pc);
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic fen, input logic rdy);
        reset = 1'b1;
        redirect_valid = 1'b0;
        fetch_en = fen;
        bus.out_ready = rdy;
        step();
        reset = 1'b0;
    endtask

    // Decode-side consumer: every accepted head must match.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc %h want none",
                         bus.out_pc);
            end else begin
                e = sb.pop_front();
                if (bus.out_pc !== e.pc ||
                    bus.out_instr !== e.instr) begin
                    errors++;
                    $display("FAIL pop: got %h/%h want %h/%h",
                             bus.out_pc, bus.out_instr,
                             e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h04, 16'd1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h08, 16'd2};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h08, 16'd2};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h04, 8'h0C, 16'd3};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 8'h08, 8'h10, 16'd4};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h0C, 8'h14, 16'd5};

        // Reset values, then streaming at one per clock.
        bus.out_ready = 1'b1;
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_instr", bus.out_instr, 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_fcnt", 32'(fetch_count), 32'd0);
        for (int i = 0; i < 5; i++) expect_pc(8'(i * 4));
        reset = 1'b0;
        step();
        step();
        chk("s1_fcnt_first", 32'(fetch_count), 32'd1);
        chk("s1_valid_first", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("s1_fcnt", 32'(fetch_count), 32'd6);
        chk("s1_head", 32'(bus.out_pc), 32'h14);
        chk("s1_addr", 32'(bus.imem_addr), 32'h18);
        bus.out_ready = 1'b0;
        fetch_en = 1'b0;
        step();
        chk("s1_drained", sb.size(), 32'd0);

        // Backpressure fill and release, table-driven.
        do_reset(1'b1, 1'b0);
        expect_pc(8'h00);
        expect_pc(8'h04);
        expect_pc(8'h08);
        for (int i = 0; i < 8; i++) begin
            fetch_en = tbl[i].fen;
            bus.out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("bp%0d_valid", i),
                32'(bus.out_valid), 32'(tbl[i].v));
            chk($sformatf("bp%0d_pc", i),
                32'(bus.out_pc), 32'(tbl[i].pc));
            chk($sformatf("bp%0d_addr", i),
                32'(bus.imem_addr), 32'(tbl[i].addr));
            chk($sformatf("bp%0d_fcnt", i),
                32'(fetch_count), 32'(tbl[i].fc));
            step();
        end
        chk("bp_drained", sb.size(), 32'd0);

        // Redirect while the buffer is full.
        do_reset(1'b1, 1'b0);
        repeat (3) step();
        chk("rd_full_pc", 32'(bus.out_pc), 32'h00);
        chk("rd_full_addr", 32'(bus.imem_addr), 32'h08);
        redirect_valid = 1'b1;
        redirect_pc = 8'h27;
        step();
        redirect_valid = 1'b0;
        chk("rd_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("rd_addr", 32'(bus.imem_addr), 32'h24);
        chk("rd_fcnt", 32'(fetch_count), 32'd2);
        bus.out_ready = 1'b1;
        expect_pc(8'h24);
        step();
        chk("rd_tgt_valid", 32'(bus.out_valid), 32'd1);
        chk("rd_tgt_pc", 32'(bus.out_pc), 32'h24);
        chk("rd_tgt_instr", bus.out_instr, 32'h0051_0293);
        step();
        bus.out_ready = 1'b0;
        fetch_en = 1'b0;
        chk("rd_fcnt_after", 32'(fetch_count), 32'd4);
        chk("rd_drained", sb.size(), 32'd0);

        // PC wrap from 0xFC to 0x00.
        do_reset(1'b1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 8'hFC;
        expect_pc(8'hFC);
        expect_pc(8'h00);
        expect_pc(8'h04);
        step();
        redirect_valid = 1'b0;
        chk("wr_addr", 32'(bus.imem_addr), 32'hFC);
        step();
        chk("wr_pc_fc", 32'(bus.out_pc), 32'hFC);
        step();
        chk("wr_pc_00", 32'(bus.out_pc), 32'h00);
        chk("wr_addr_04", 32'(bus.imem_addr), 32'h04);
        step();
        step();
        bus.out_ready = 1'b0;
        chk("wr_drained", sb.size(), 32'd0);

        // Halt for three cycles while the buffer drains.
        do_reset(1'b1, 1'b0);
        repeat (3) step();
        fetch_en = 1'b0;
        bus.out_ready = 1'b1;
        expect_pc(8'h00);
        expect_pc(8'h04);
        expect_pc(8'h08);
        step();
        chk("hl_addr_frozen", 32'(bus.imem_addr), 32'h08);
        step();
        step();
        chk("hl_addr_held", 32'(bus.imem_addr), 32'h08);
        chk("hl_fcnt", 32'(fetch_count), 32'd2);
        chk("hl_empty", 32'(bus.out_valid), 32'd0);
        fetch_en = 1'b1;
        step();
        chk("hl_no_push_yet", 32'(bus.out_valid), 32'd0);
        chk("hl_addr_same", 32'(bus.imem_addr), 32'h08);
        step();
        chk("hl_resume_valid", 32'(bus.out_valid), 32'd1);
        chk("hl_resume_pc", 32'(bus.out_pc), 32'h08);
        chk("hl_resume_addr", 32'(bus.imem_addr), 32'h0C);
        chk("hl_resume_fcnt", 32'(fetch_count), 32'd3);
        step();
        bus.out_ready = 1'b0;
        fetch_en = 1'b0;
        chk("hl_drained", sb.size(), 32'd0);

        // Asynchronous reset mid-cycle with two buffered.
        do_reset(1'b1, 1'b0);
        repeat (3) step();
        chk("ar_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_addr", 32'(bus.imem_addr), 32'd0);
        chk("ar_fcnt", 32'(fetch_count), 32'd0);
        chk("ar_pc", 32'(bus.out_pc), 32'd0);
        chk("ar_instr", bus.out_instr, 32'd0);
        step();
        reset = 1'b0;
        fetch_en = 1'b1;
        bus.out_ready = 1'b1;
        expect_pc(8'h00);
        expect_pc(8'h04);
        step();
        step();
        chk("ar_boot_valid", 32'(bus.out_valid), 32'd1);
        chk("ar_boot_pc", 32'(bus.out_pc), 32'h00);
        step();
        step();
        bus.out_ready = 1'b0;
        chk("ar_drained", sb.size(), 32'd0);

        step();
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Initiator side of the instruction-memory interface. Holds the program counter, drives the word-aligned byte address into the combinational instruction memory, and captures each returned 32-bit word with its PC into a 2-entry fetch buffer. Presents the buffer head to decode over a valid/ready handshake, with backpressure, halt, and branch/jump redirect (flush). Sits between the instruction memory and the decode stage.

## Interface
- `ADDR_W`, 8: byte-address width; the PC and `imem_addr` wrap modulo 2^ADDR_W.
- `RESET_PC`, 8'h00: PC value loaded at reset; bits [1:0] must be 0.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `fetch_en` input 1: 1 = fetching allowed; 0 = halt (no new pushes, PC held).
- `redirect_valid` input 1: flush request from execute (branch/jump taken).
- `redirect_pc` input ADDR_W: new fetch address; bits [1:0] ignored (forced 0).
- `imem_addr` output ADDR_W: byte address to instruction memory; always equals `pc`, bits [1:0] = 0.
- `imem_instr` input 32: combinational read data for `imem_addr`, valid in the same cycle.
- `out_valid` output 1: buffer head holds an instruction.
- `out_ready` input 1: decode accepts the head this cycle.
- `out_instr` output 32: head instruction.
- `out_pc` output ADDR_W: byte address of the head instruction.
- `fetch_count` output 16: instructions pushed since reset; saturates at 16'hFFFF.

## Operation
- Registers: `pc`, 2-entry FIFO of {pc, instr} (`wr_ptr`, `rd_ptr`, `count` 0..2), `fetch_count`, FSM state.
- FSM states: BOOT, RUN, HALT.
  - BOOT: entered on reset. No push. Next state is RUN if `fetch_en`, otherwise HALT.
  - RUN: a push occurs when `fetch_en` = 1 and (`count` < 2 or pop this cycle). On `fetch_en` = 0, go to HALT with no push that cycle.
  - HALT: no push, `pc` held. Return to RUN in the cycle after `fetch_en` = 1.
- pop = `out_valid` & `out_ready`.
- push: write {`pc`, `imem_instr`} at `wr_ptr`, then `pc` <= `pc` + 4 (mod 2^ADDR_W, so 8'hFC wraps to 8'h00), and `fetch_count` += 1 (saturating).
- A simultaneous push and pop when `count` = 2 is allowed; `count` stays 2.
- Redirect has top priority in every state:
  - `pc` <= {`redirect_pc`[ADDR_W-1:2], 2'b00}.
  - FIFO cleared (`count` = 0, pointers = 0).
  - No push that cycle; `fetch_count` unchanged.
  - RUN/HALT state unchanged.
  - A pop in the same cycle counts as consumed by decode; decode must discard it.
- `out_valid` = (`count` != 0). `out_instr`/`out_pc` come from the entry at `rd_ptr`, and are 0 when empty.

## Timing
- Reset values: `pc` = RESET_PC, `imem_addr` = RESET_PC, `out_valid` = 0, `out_instr` = 0, `out_pc` = 0, `fetch_count` = 0, state = BOOT, `count` = 0.
- Fetch latency: `imem_addr` changes on edge N; the instruction is captured on edge N+1 and visible on `out_*` immediately after.
- After reset deasserts with `fetch_en` = 1:
  - edge 1: BOOT → RUN.
  - edge 2: first push, so `out_valid` = 1 with `out_pc` = RESET_PC.
- Sustained throughput is 1 instruction/clock while `out_ready` = 1.
- With `out_ready` = 0 the FIFO fills in 2 pushes; `pc` then stalls at head PC + 8.
- Redirect on edge N: `imem_addr` = target after N; the first target instruction appears on `out_*` after edge N+1.
- Reset asserted mid-stream: outputs take their reset values asynchronously; any in-flight push is dropped.

## Structure
- Shared package `riscv_pkg`: `XLEN` = 32, `IMEM_ADDR_W` = 8, `RESET_PC`, `NOP_INSTR` = 32'h0000_0013, FSM state enum `fetch_state_t`.
- One sub-module: `fetch_fifo`, a 2-entry synchronous FIFO parameterised on data width (ADDR_W+32), with push/pop/flush/count ports.
- PC, FSM and counter logic live in `instr_fetch_unit`.

## Test plan
- Reset, `fetch_en` = 1, `out_ready` = 1, memory holding the current program → `out_pc` sequence 0x00, 0x04, 0x08, … with `out_instr` 32'h0000_7033, 32'h0030_0093, 32'h0020_0113, one per cycle starting at edge 2; `fetch_count` increments each cycle.
- Hold `out_ready` = 0 from start → after 2 pushes, `out_valid` = 1, `out_pc` = 0x00, `imem_addr` = 0x08 held. Release → 0x00, 0x04, 0x08 delivered on consecutive cycles with no bubble.
- `redirect_valid` = 1 with `redirect_pc` = 8'h27 while FIFO is full → FIFO emptied next cycle, `imem_addr` = 0x24, next `out_pc` = 0x24 with `out_instr` = 32'h0051_0293.
- Start at `pc` = 0xFC via redirect → `out_pc` 0xFC, then 0x00 (wrap), with no error or stall.
- Drop `fetch_en` for 3 cycles mid-stream → no pushes, `pc` frozen, buffered entries still drain; fetching resumes at the same PC one cycle after re-enable.
- Assert `reset` asynchronously mid-cycle with 2 entries buffered → `out_valid` = 0, `imem_addr` = 0x00, `fetch_count` = 0 immediately; normal boot follows release.
